// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and controller states.
// Legacy 3-bit codes keep their values in the low bits with op[3] = 0.
package alu_pkg;

    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_PASSA = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_AND   = 4'b1000;
    localparam logic [3:0] ALU_XOR   = 4'b1001;
    localparam logic [3:0] ALU_SLT   = 4'b1010;
    localparam logic [3:0] ALU_MULU  = 4'b1100;
    localparam logic [3:0] ALU_DIVU  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the register-read stage, the ALU and writeback.
// master = requester/consumer side, slave = the ALU.
interface alu_mc_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             div0;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, carry, overflow, div0
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, zero, carry, overflow, div0
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// lo/hi carry the finished values combinationally in the cycle done is high.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic             last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;

    // NOTE: every _d takes its hold value first so no path through this block infers a latch.
    always_comb begin
        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;

        // Multiply: hi accumulates, lo holds the not-yet-consumed multiplier bits.
        mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, opb_q};
        last      = busy_q && (cnt_q == CW'(WIDTH - 1));

        if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = a;
            opb_d    = b;
        end else if (busy_q) begin
            if (is_div_q) begin
                if (rem_shift >= {1'b0, opb_q}) begin
                    hi_d = rem_trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = rem_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end

            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
        end
    end

    assign lo   = lo_d;
    assign hi   = hi_d;
    assign done = last;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle WIDTH-bit ALU with valid/ready handshake: single-cycle ops plus iterative mulu/divu.
// All outputs are registered and held in DONE until the consumer takes them.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             div0_q, div0_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   ext_a, ext_b, ext_sum, ext_diff, ext_or;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign md_start = accept && ((bus.op == ALU_MULU) ||
                                 ((bus.op == ALU_DIVU) && (bus.b != '0)));

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (bus.op == ALU_DIVU),
        .a      (bus.a),
        .b      (bus.b),
        .lo     (md_lo),
        .hi     (md_hi),
        .done   (md_done)
    );

    // Legacy semantics: add/sub/or operate on sign-extended WIDTH+1-bit operands.
    always_comb begin
        ext_a     = {bus.a[WIDTH-1], bus.a};
        ext_b     = {bus.b[WIDTH-1], bus.b};
        ext_sum   = ext_a + ext_b;
        ext_diff  = ext_a - ext_b;
        ext_or    = ext_a | ext_b;
        alu_res   = bus.b;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                alu_res   = ext_sum[WIDTH-1:0];
                alu_carry = ext_sum[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (ext_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res   = ext_diff[WIDTH-1:0];
                alu_carry = ext_diff[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (ext_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_OR: begin
                alu_res   = ext_or[WIDTH-1:0];
                alu_carry = ext_or[WIDTH];
            end
            ALU_PASSA: alu_res = bus.a;
            ALU_AND:   alu_res = bus.a & bus.b;
            ALU_XOR:   alu_res = bus.a ^ bus.b;
            ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default:   alu_res = bus.b;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        div0_d      = div0_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == ALU_MULU) begin
                        state_d = MUL;
                    end else if ((bus.op == ALU_DIVU) && (bus.b != '0)) begin
                        state_d = DIV;
                    end else if (bus.op == ALU_DIVU) begin
                        result_d    = '1;
                        result_hi_d = bus.a;
                        carry_d     = 1'b0;
                        overflow_d  = 1'b0;
                        div0_d      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        carry_d     = alu_carry;
                        overflow_d  = alu_ovf;
                        div0_d      = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    result_d    = md_lo;
                    result_hi_d = md_hi;
                    carry_d     = 1'b0;
                    overflow_d  = 1'b0;
                    div0_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // zero tracks the low word only; result_hi never affects it.
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            div0_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            div0_q      <= div0_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.div0      = div0_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases, then random ops against an
// arithmetic reference model (64-bit integer maths, / and %).
module tb_alu_mc;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         carry;
        logic         ovf;
        logic         div0;
        logic [7:0]   lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb, s, max_s, min_s;
        logic [63:0] sv, p;
        max_s = 64'sd2147483647;
        min_s = -max_s - 1;
        sa = $signed(a);
        sb = $signed(b);
        e = '0;
        e.lat = 8'd1;
        case (op)
            4'h2: begin
                s = sa + sb; sv = s;
                e.res = sv[31:0]; e.carry = sv[32];
                e.ovf = (s > max_s) || (s < min_s);
            end
            4'h6: begin
                s = sa - sb; sv = s;
                e.res = sv[31:0]; e.carry = sv[32];
                e.ovf = (s > max_s) || (s < min_s);
            end
            4'h1: begin
                s = sa | sb; sv = s;
                e.res = sv[31:0]; e.carry = sv[32];
            end
            4'h5: e.res = a;
            4'h7: e.res = b;
            4'h8: e.res = a & b;
            4'h9: e.res = a ^ b;
            4'hA: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'hC: begin
                p = 64'(a) * 64'(b);
                e.res = p[31:0]; e.hi = p[63:32];
                e.lat = 8'd33;
            end
            4'hD: begin
                if (b == 0) begin
                    e.res = '1; e.hi = a; e.div0 = 1'b1;
                end else begin
                    e.res = a / b; e.hi = a % b;
                    e.lat = 8'd33;
                end
            end
            default: e.res = b;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    endtask

    // Entered at a negedge; returns at the first negedge with out_valid high (or budget spent).
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic verify(input string tag, input exp_t e, input int lat);
        check({tag, "_lat"},       64'(lat),           64'(e.lat));
        check({tag, "_valid"},     64'(bus.out_valid), 64'd1);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, "_result"},    64'(bus.result),    64'(e.res));
        check({tag, "_result_hi"}, 64'(bus.result_hi), 64'(e.hi));
        check({tag, "_zero"},      64'(bus.zero),      64'(e.zero));
        check({tag, "_carry"},     64'(bus.carry),     64'(e.carry));
        check({tag, "_overflow"},  64'(bus.overflow),  64'(e.ovf));
        check({tag, "_div0"},      64'(bus.div0),      64'(e.div0));
    endtask

    task automatic hold(input string tag, input exp_t e, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"},    64'(bus.out_valid), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready),  64'd0);
            check({tag, "_hold_result"},   64'(bus.result),    64'(e.res));
            check({tag, "_hold_hi"},       64'(bus.result_hi), 64'(e.hi));
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_rel_valid"},    64'(bus.out_valid), 64'd0);
        check({tag, "_rel_in_ready"}, 64'(bus.in_ready),  64'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold_cycles);
        exp_t e;
        int   lat;
        e = model(op, a, b);
        issue(op, a, b, lat);
        verify(tag, e, lat);
        hold(tag, e, hold_cycles);
        release_out(tag);
    endtask

    initial begin
        exp_t        e;
        int          lat;
        logic [3:0]  rop;
        logic [W-1:0] ra, rb;

        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_result_hi", 64'(bus.result_hi), 64'd0);
        check("rst_zero",      64'(bus.zero),      64'd1);
        check("rst_carry",     64'(bus.carry),     64'd0);
        check("rst_overflow",  64'(bus.overflow),  64'd0);
        check("rst_div0",      64'(bus.div0),      64'd0);

        // out_ready while idle must not disturb anything
        release_out("idle_ready");

        run_op("add_ovf",  4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_zero", 4'h6, 32'd5,         32'd5,         0);
        run_op("sub_neg",  4'h6, 32'h8000_0000, 32'd1,         0);
        run_op("slt_neg",  4'hA, 32'hFFFF_FFFF, 32'd1,         0);
        run_op("or_sign",  4'h1, 32'h8000_0000, 32'h0000_00F0, 0);
        run_op("pass_a",   4'h5, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("mul_max",  4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        run_op("div_100_7",4'hD, 32'd100,       32'd7,         0);
        run_op("div_zero", 4'hD, 32'd9,         32'd0,         0);
        run_op("op_e",     4'hE, 32'hAAAA_AAAA, 32'h0000_BEEF, 0);

        // No accept in DONE even with out_ready high; request is taken one cycle later.
        e = model(4'h9, 32'hF0F0_0000, 32'h0F0F_0000);
        issue(4'h9, 32'hF0F0_0000, 32'h0F0F_0000, lat);
        verify("xor", e, lat);
        e = model(4'h8, 32'hFF00_FF00, 32'h0FF0_0FF0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'h8;
        bus.a         = 32'hFF00_FF00;
        bus.b         = 32'h0FF0_0FF0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b_no_accept_valid", 64'(bus.out_valid), 64'd0);
        check("b2b_idle_ready",      64'(bus.in_ready),  64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_and_valid",  64'(bus.out_valid), 64'd1);
        check("b2b_and_result", 64'(bus.result),    64'(e.res));
        release_out("b2b");

        // Asynchronous reset in the middle of a multiply.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.op       = 4'hC;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midmul_busy", 64'(bus.in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midmul_async_in_ready", 64'(bus.in_ready),  64'd1);
        check("midmul_async_result",   64'(bus.result),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midmul_in_ready",  64'(bus.in_ready),  64'd1);
        check("midmul_out_valid", 64'(bus.out_valid), 64'd0);
        check("midmul_result",    64'(bus.result),    64'd0);
        check("midmul_zero",      64'(bus.zero),      64'd1);
        run_op("mul_after_rst", 4'hC, 32'd12345, 32'd6789, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_op("rand", rop, ra, rb, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: successor to the single-cycle datapath ALU, generalised to WIDTH bits.
- Keeps the legacy 3-bit operation codes bit-compatible in a 4-bit op field.
- Adds AND/XOR/SLT and iterative unsigned multiply and divide.
- Operations are exchanged over a valid/ready handshake, so the control unit can stall on long operations.
- Sits between the register-file read stage and the writeback mux of the datapath.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request (IDLE)
- op  in  4  operation code (see Operation)
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- out_valid  out  1  result registers hold a completed result
- out_ready  in  1  consumer takes result
- result  out  WIDTH  main result (mul low word, div quotient)
- result_hi  out  WIDTH  mul high word, div remainder; 0 for other ops
- zero  out  1  result == 0
- carry  out  1  bit WIDTH of the sign-extended WIDTH+1-bit add/sub/or (legacy semantics); 0 otherwise
- overflow  out  1  signed overflow for add/sub; 0 otherwise
- div0  out  1  divide by zero occurred

## Operation
- Codes:
  - 0010 add, 0110 sub, 0001 or, 0101 pass a, 0111 pass b.
  - 1000 and, 1001 xor, 1010 slt signed (result 1/0).
  - 1100 mulu, 1101 divu.
  - Any other code: pass b.
- States: IDLE, MUL, DIV, DONE. in_ready = (state == IDLE).
- IDLE, in_valid:
  - Non-iterative op: result/flags registered → DONE.
  - mulu: latch operands, clear accumulator, cnt = 0 → MUL.
  - divu with b ≠ 0: latch operands, cnt = 0 → DIV.
  - divu with b == 0: result = all ones, result_hi = a, div0 = 1 → DONE directly.
- MUL: shift-add, one multiplier bit per cycle. After cnt == WIDTH-1: {result_hi, result} = a*b (2·WIDTH-bit unsigned) → DONE.
- DIV: restoring division, one quotient bit per cycle. After cnt == WIDTH-1: quotient → result, remainder → result_hi → DONE.
- Flags in MUL/DIV: carry = overflow = 0. zero = (result == 0); result_hi is ignored.
- Arithmetic rules:
  - add/sub/or are computed as {a[W-1],a} op {b[W-1],b}; carry = bit W of that value.
  - overflow = operand signs equal (add) or differ (sub), and result sign differs from a's sign.
- DONE: all outputs held stable. out_valid = 1. On out_ready → IDLE, out_valid falls next cycle.
- Operands are captured at acceptance. Changes on a/b/op while busy are ignored.

## Timing
- Reset (asynchronous, any state, including mid-MUL/DIV):
  - state = IDLE; cnt and operand registers = 0.
  - result, result_hi = 0; zero = 1 (consistent with result 0).
  - carry, overflow, div0, out_valid = 0.
  - in_ready = 1 from the first edge after rst_n deasserts.
- Latency from accept edge to out_valid:
  - Non-iterative ops and divide-by-zero: 1 cycle.
  - mulu/divu: WIDTH+1 cycles.
- Throughput: at most one accept per 2 cycles. There is no accept while in DONE, even when out_ready = 1.
- out_ready while out_valid = 0: ignored.
- out_ready held low: result held indefinitely, no loss.
- in_valid while in_ready = 0: not accepted. The requester must hold the request.
- cnt width: $clog2(WIDTH). cnt wraps only via state exit, never on its own.

## Structure
- Shared package alu_pkg:
  - op code localparams (ALU_ADD, ALU_SUB, ALU_OR, ALU_PASSA, ALU_PASSB, ALU_AND, ALU_XOR, ALU_SLT, ALU_MULU, ALU_DIVU);
  - state enum alu_state_t.
- One sub-module, alu_muldiv_iter: the shift-add/restoring datapath.
  - Takes start, is_div, a, b.
  - Returns lo, hi, done.
- Combinational single-cycle ops and the FSM stay in alu_mc.

## Test plan
- Reset mid-MUL (WIDTH = 32, cycle 10 of mulu) → next cycle in_ready = 1, out_valid = 0, result = 0, zero = 1.
- add a = 0x7FFFFFFF, b = 1 → 1 cycle later:
  - result = 0x80000000, overflow = 1, carry = 0, zero = 0.
- sub a = 5, b = 5 → result = 0, zero = 1. slt a = 0xFFFFFFFF, b = 1 → result = 1.
- mulu a = 0xFFFFFFFF, b = 0xFFFFFFFF:
  - out_valid exactly 33 cycles after accept;
  - result_hi = 0xFFFFFFFE, result = 0x00000001.
- divu a = 100, b = 7 → quotient 14, remainder 2 after 33 cycles.
- divu a = 9, b = 0 → 1 cycle later: result = 0xFFFFFFFF, result_hi = 9, div0 = 1.
- out_ready held low 5 cycles in DONE → outputs stable, in_ready = 0. out_ready pulse → IDLE next cycle. Unknown op 0xE → result = b.
